// File: rtl/sd_block_writer.sv
// SD 4-bit single-block write engine: streams one sector from RAM onto DAT[3:0]
// with per-line CRC16, then collects the card's CRC-status token and busy release.
module sd_block_writer #(
  parameter int BLOCK_NIBBLES  = 1024,
  parameter int STATUS_TIMEOUT = 64,
  parameter int BUSY_TIMEOUT   = 250000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENA,
  output logic [9:0] RADDR,
  input  logic [3:0] RDATA,
  output logic [3:0] DATA_OUT,
  output logic       DATA_OE,
  input  logic       DAT0_IN,
  output logic       COMPLT,
  output logic       CRCERROR,
  output logic       WRITEERROR,
  output logic       NORESPERROR
);
  localparam int NUM_LANES = 4;
  localparam int CW = $clog2(BUSY_TIMEOUT + BLOCK_NIBBLES + STATUS_TIMEOUT + 1);
  localparam logic [CW-1:0] NIB_LAST  = CW'(BLOCK_NIBBLES);
  localparam logic [CW-1:0] STAT_LAST = CW'(STATUS_TIMEOUT - 1);
  localparam logic [CW-1:0] BUSY_LAST = CW'(BUSY_TIMEOUT - 1);
  localparam logic [9:0]    ADDR_LAST = 10'(BLOCK_NIBBLES - 1);
  localparam logic [15:0]   POLY      = 16'h1021;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DATA, S_CRC, S_END, S_STAT_WAIT, S_STAT, S_BUSY, S_DONE
  } state_t;

  state_t                             state;
  logic [CW-1:0]                      cnt;
  logic [2:0]                         stat_sr;
  logic [NUM_LANES-1:0][15:0]         crc_q, crc_nx;
  logic [NUM_LANES-1:0]               crc_top, crc_b14;

  // Each line's CRC advances on the bit it is driving this cycle.
  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      logic fb;
      assign fb         = crc_q[g][15] ^ DATA_OUT[g];
      assign crc_nx[g]  = {crc_q[g][14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
      assign crc_top[g] = crc_nx[g][15];
      assign crc_b14[g] = crc_q[g][14];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      stat_sr     <= '0;
      crc_q       <= '0;
      RADDR       <= '0;
      DATA_OUT    <= 4'hF;
      DATA_OE     <= 1'b0;
      COMPLT      <= 1'b0;
      CRCERROR    <= 1'b0;
      WRITEERROR  <= 1'b0;
      NORESPERROR <= 1'b0;
    end else if (!ENA) begin
      state       <= S_IDLE;
      cnt         <= '0;
      RADDR       <= '0;
      DATA_OUT    <= 4'hF;
      DATA_OE     <= 1'b0;
      COMPLT      <= 1'b0;
      CRCERROR    <= 1'b0;
      WRITEERROR  <= 1'b0;
      NORESPERROR <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_START;
          DATA_OUT <= 4'h0;
          DATA_OE  <= 1'b1;
          RADDR    <= 10'd1;
          crc_q    <= '0;
          cnt      <= '0;
        end
        S_START: begin
          state    <= S_DATA;
          DATA_OUT <= RDATA;
          RADDR    <= (RADDR == ADDR_LAST) ? RADDR : RADDR + 10'd1;
          crc_q    <= '0;
          cnt      <= CW'(1);
        end
        S_DATA: begin
          crc_q <= crc_nx;
          if (cnt == NIB_LAST) begin
            // Last nibble is on the bus now; its CRC contribution lands here too.
            state    <= S_CRC;
            DATA_OUT <= crc_top;
            RADDR    <= '0;
            cnt      <= '0;
          end else begin
            DATA_OUT <= RDATA;
            RADDR    <= (RADDR == ADDR_LAST) ? RADDR : RADDR + 10'd1;
            cnt      <= cnt + 1'b1;
          end
        end
        S_CRC: begin
          for (int i = 0; i < NUM_LANES; i++) crc_q[i] <= {crc_q[i][14:0], 1'b0};
          if (cnt == CW'(15)) begin
            state    <= S_END;
            DATA_OUT <= 4'hF;
          end else begin
            DATA_OUT <= crc_b14;
            cnt      <= cnt + 1'b1;
          end
        end
        S_END: begin
          state    <= S_STAT_WAIT;
          DATA_OE  <= 1'b0;
          DATA_OUT <= 4'hF;
          cnt      <= CW'(1);
        end
        S_STAT_WAIT: begin
          if (!DAT0_IN) begin
            state <= S_STAT;
            cnt   <= '0;
          end else if (cnt == STAT_LAST) begin
            state       <= S_DONE;
            COMPLT      <= 1'b1;
            NORESPERROR <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STAT: begin
          if (cnt == CW'(3)) begin
            cnt <= '0;
            if (DAT0_IN && stat_sr == 3'b010) begin
              state <= S_BUSY;
            end else begin
              state  <= S_DONE;
              COMPLT <= 1'b1;
              if (DAT0_IN && stat_sr == 3'b101) CRCERROR   <= 1'b1;
              else                              WRITEERROR <= 1'b1;
            end
          end else begin
            stat_sr <= {stat_sr[1:0], DAT0_IN};
            cnt     <= cnt + 1'b1;
          end
        end
        S_BUSY: begin
          // The first two cycles are the card's turnaround and may read high.
          if (cnt >= CW'(2) && DAT0_IN) begin
            state  <= S_DONE;
            COMPLT <= 1'b1;
          end else if (cnt == BUSY_LAST) begin
            state       <= S_DONE;
            COMPLT      <= 1'b1;
            NORESPERROR <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_block_writer.sv
// Bench for sd_block_writer: full-block bus checks against a sector/CRC model,
// table-driven card responses, plus abort and async-reset sequences.
module tb_sd_block_writer;
  localparam int ST = 64;
  localparam int BT = 400;

  logic       CLK = 1'b0;
  logic       RST, ENA, DAT0_IN;
  logic [3:0] RDATA;
  logic [9:0] RADDR;
  logic [3:0] DATA_OUT;
  logic       DATA_OE, COMPLT, CRCERROR, WRITEERROR, NORESPERROR;

  int errs = 0;
  int checks = 0;

  logic [3:0] ram     [0:1023];
  logic [3:0] exp_bus [0:1041];
  logic [9:0] exp_ra  [0:1041];

  typedef struct {
    int         mode;
    bit         send;
    int         dly;
    logic [4:0] tok;
    int         blen;
    int         xoff;
    logic [2:0] xfl;
  } vec_t;

  vec_t tbl [9];

  sd_block_writer #(.BLOCK_NIBBLES(1024), .STATUS_TIMEOUT(ST), .BUSY_TIMEOUT(BT)) dut (
    .CLK(CLK), .RST(RST), .ENA(ENA), .RADDR(RADDR), .RDATA(RDATA),
    .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DAT0_IN(DAT0_IN), .COMPLT(COMPLT),
    .CRCERROR(CRCERROR), .WRITEERROR(WRITEERROR), .NORESPERROR(NORESPERROR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) RDATA <= ram[RADDR];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".oe"},    32'(DATA_OE), 0);
    chk({nm, ".raddr"}, 32'(RADDR), 0);
    chk({nm, ".dat"},   32'(DATA_OUT), 32'hF);
    chk({nm, ".complt"}, 32'(COMPLT), 0);
    chk({nm, ".flags"}, 32'({CRCERROR, WRITEERROR, NORESPERROR}), 0);
  endtask

  task automatic fill_ram(input int mode);
    for (int a = 0; a < 1024; a++)
      ram[a] = (mode == 0) ? 4'h0 : (mode == 1) ? 4'(a) : 4'($urandom);
  endtask

  // Expected bus per cycle: start, sector nibbles, each line's CRC16 MSB first, end.
  task automatic build_exp();
    logic [15:0] c [4];
    for (int l = 0; l < 4; l++) begin
      c[l] = 16'h0;
      for (int j = 0; j < 1024; j++) begin
        logic fb;
        fb = c[l][15] ^ ram[j][l];
        c[l] = {c[l][14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0);
      end
    end
    exp_bus[0] = 4'h0;
    for (int j = 0; j < 1024; j++) exp_bus[1 + j] = ram[j];
    for (int b = 0; b < 16; b++)
      for (int l = 0; l < 4; l++) exp_bus[1025 + b][l] = c[l][15 - b];
    exp_bus[1041] = 4'hF;
    for (int k = 0; k < 1042; k++)
      exp_ra[k] = (k >= 1025) ? 10'd0 : (k + 1 > 1023) ? 10'd1023 : 10'(k + 1);
  endtask

  function automatic logic dat0_at(input int t, input int dly, input logic [4:0] tok,
                                   input bit send, input int blen);
    if (send && t >= dly && t <= dly + 4) return tok[4 - (t - dly)];
    if (send && t >= dly + 5 && t < dly + 5 + blen) return 1'b0;
    return 1'b1;
  endfunction

  // Outcome from the protocol rules: offset after the end bit when COMPLT rises, and flags.
  function automatic void predict(input int dly, input logic [4:0] tok, input bit send,
                                  input int blen, output int off, output logic [2:0] fl);
    int b, rel;
    if (!send || dly >= ST) begin
      off = ST; fl = 3'b001;
    end else if (tok[0] && tok[3:1] == 3'b010) begin
      b = dly + 5;
      rel = (blen > 2) ? b + blen : b + 2;
      if (rel > b + BT - 1) begin off = b + BT; fl = 3'b001; end
      else begin off = rel + 1; fl = 3'b000; end
    end else if (tok[0] && tok[3:1] == 3'b101) begin
      off = dly + 5; fl = 3'b100;
    end else begin
      off = dly + 5; fl = 3'b010;
    end
  endfunction

  task automatic run_block(input int stop_at, input bit by_rst);
    build_exp();
    ENA = 1'b1;
    DAT0_IN = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 1042; k++) begin
      chk("bus.oe", 32'(DATA_OE), 1);
      chk("bus.dat", 32'(DATA_OUT), 32'(exp_bus[k]));
      chk("bus.raddr", 32'(RADDR), 32'(exp_ra[k]));
      chk("bus.complt", 32'(COMPLT), 0);
      if (k == stop_at) begin
        if (by_rst) begin
          #2 RST = 1'b0;
          #1 chk_idle("data_rst");
          @(negedge CLK);
          chk_idle("data_rst_hold");
          RST = 1'b1;
        end else begin
          ENA = 1'b0;
          @(negedge CLK);
          chk_idle("abort");
          repeat (3) begin
            @(negedge CLK);
            chk_idle("abort_idle");
          end
        end
        return;
      end
      @(negedge CLK);
    end
    chk("post.oe", 32'(DATA_OE), 0);
    chk("post.dat", 32'(DATA_OUT), 32'hF);
  endtask

  task automatic respond(input int dly, input logic [4:0] tok, input bit send, input int blen,
                         input int xoff, input logic [2:0] xfl, input int rst_at);
    for (int t = 1; t <= xoff + 3; t++) begin
      DAT0_IN = dat0_at(t, dly, tok, send, blen);
      if (t == rst_at) begin
        #2 RST = 1'b0;
        #1 chk_idle("busy_rst");
        @(negedge CLK);
        RST = 1'b1;
        DAT0_IN = 1'b1;
        return;
      end
      chk("resp.oe", 32'(DATA_OE), 0);
      chk("resp.complt", 32'(COMPLT), 32'(t >= xoff));
      chk("resp.flags", 32'({CRCERROR, WRITEERROR, NORESPERROR}), (t >= xoff) ? 32'(xfl) : 0);
      @(negedge CLK);
    end
    ENA = 1'b0;
    DAT0_IN = 1'b1;
    @(negedge CLK);
    chk_idle("ack");
  endtask

  initial begin
    int off;
    logic [2:0] fl;
    int dly, blen, r;
    logic [4:0] tok;

    // mode, send, dly, tok (start bit first), busy len, COMPLT offset, {CRC,WRITE,NORESP}
    tbl[0] = '{0, 1'b0,  0, 5'b00000,    0,  64, 3'b001};
    tbl[1] = '{1, 1'b1,  3, 5'b00101,  100, 109, 3'b000};
    tbl[2] = '{2, 1'b1,  3, 5'b01011,    0,   8, 3'b100};
    tbl[3] = '{2, 1'b1,  3, 5'b01101,    0,   8, 3'b010};
    tbl[4] = '{2, 1'b1,  3, 5'b00100,    0,   8, 3'b010};
    tbl[5] = '{1, 1'b1, 63, 5'b00101,    0,  71, 3'b000};
    tbl[6] = '{0, 1'b1, 64, 5'b00101,    0,  64, 3'b001};
    tbl[7] = '{2, 1'b1,  1, 5'b00101, 1000, 406, 3'b001};
    tbl[8] = '{2, 1'b1,  1, 5'b01001,    0,   6, 3'b010};

    RST = 1'b0; ENA = 1'b0; DAT0_IN = 1'b1;
    fill_ram(0);
    repeat (2) @(negedge CLK);
    chk_idle("reset");
    RST = 1'b1;
    @(negedge CLK);
    chk_idle("idle");

    foreach (tbl[i]) begin
      fill_ram(tbl[i].mode);
      run_block(-1, 1'b0);
      respond(tbl[i].dly, tbl[i].tok, tbl[i].send, tbl[i].blen, tbl[i].xoff, tbl[i].xfl, -1);
    end

    // Abort mid-data, then a clean restart of the same sector.
    fill_ram(2);
    run_block(501, 1'b0);
    run_block(-1, 1'b0);
    predict(3, 5'b00101, 1'b1, 10, off, fl);
    respond(3, 5'b00101, 1'b1, 10, off, fl, -1);

    // Async reset while driving data with ENA still high, then a full block.
    run_block(300, 1'b1);
    fill_ram(2);
    run_block(-1, 1'b0);
    predict(5, 5'b01011, 1'b1, 0, off, fl);
    respond(5, 5'b01011, 1'b1, 0, off, fl, -1);

    // Async reset during busy, then a full block.
    run_block(-1, 1'b0);
    predict(3, 5'b00101, 1'b1, 200, off, fl);
    respond(3, 5'b00101, 1'b1, 200, off, fl, 50);
    run_block(-1, 1'b0);
    predict(2, 5'b00101, 1'b1, 7, off, fl);
    respond(2, 5'b00101, 1'b1, 7, off, fl, -1);

    for (int n = 0; n < 5; n++) begin
      fill_ram(2);
      dly  = $urandom_range(1, 70);
      blen = $urandom_range(0, 450);
      r    = $urandom_range(0, 3);
      tok  = (r < 2) ? 5'b00101 : (r == 2) ? 5'b01011 : {1'b0, 4'($urandom)};
      predict(dly, tok, 1'b1, blen, off, fl);
      run_block(-1, 1'b0);
      respond(dly, tok, 1'b1, blen, off, fl, -1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sd_block_writer.md
Name: sd_block_writer

Overview:
Transmit side of the SD 4-bit data bus for single-block writes. On enable, it reads 1024 nibbles (one 512-byte sector) from the sector RAM and drives them on DAT[3:0] in this order: start bit, data, per-line CRC16, end bit. It then receives the card's CRC-status token on DAT0 and waits out the card busy period. It sits beside the block reader under the SD controller and shares the sector RAM read port.

Parameters:
BLOCK_NIBBLES, 1024, data nibbles per block (512 bytes × 2)
STATUS_TIMEOUT, 64, max CLK cycles after the end bit to wait for the status start bit
BUSY_TIMEOUT, 250000, max CLK cycles to wait for DAT0 release after the status token

Ports:
CLK  in  1  SD bus clock; all logic on posedge
RST  in  1  asynchronous reset, active-low
ENA  in  1  level enable; rising to 1 starts a block, 0 aborts or acknowledges
RADDR  out  10  sector RAM read address
RDATA  in  4  sector RAM read data; registered RAM with 1-cycle read latency
DATA_OUT  out  4  DAT[3:0] drive value
DATA_OE  out  1  DAT[3:0] output enable (1 = block drives bus)
DAT0_IN  in  1  sampled DAT0 (card status / busy)
COMPLT  out  1  block finished (success or error); held until ENA=0
CRCERROR  out  1  card returned CRC-error status (101)
WRITEERROR  out  1  card returned any status other than 010 or 101
NORESPERROR  out  1  status or busy timeout expired

Behaviour:
- Reset (RST=0, async): state=IDLE; RADDR=0; DATA_OUT=4'hF; DATA_OE=0; COMPLT, CRCERROR, WRITEERROR and NORESPERROR all 0; CRC registers 0; counters 0.
- States: IDLE, START, DATA, CRC, END, STAT_WAIT, STAT, BUSY, DONE.
- IDLE: RADDR held at 0, so RDATA holds nibble 0. ENA=1 moves to START.
- Bus timeline, numbered by cycle k after leaving IDLE:
  - k=0 (START): DATA_OUT=0000, DATA_OE=1, RADDR=1.
  - k=1..1024 (DATA): DATA_OUT=RAM[k-1]; RADDR leads by one address, saturates at 1023 and returns to 0 after DATA.
  - k=1025..1040 (CRC): each line outputs its own CRC16, MSB first.
  - k=1041 (END): DATA_OUT=1111.
  - k=1042: DATA_OE=0, DATA_OUT=1111; state moves to STAT_WAIT.
- Bit mapping: RAM nibble bit n goes to DAT[n].
- CRC per line: polynomial x^16+x^12+x^5+1, init 0x0000, computed over that line's 1024 data bits only. CRCs are cleared in START.
- STAT_WAIT:
  - Counts cycles; DAT0_IN=0 sampled moves to STAT.
  - If the count reaches STATUS_TIMEOUT: NORESPERROR=1, go to DONE.
- STAT: shifts 3 status bits, then samples the end bit.
  - 010: go to BUSY.
  - 101: CRCERROR=1, go to DONE.
  - Any other code, or end bit 0: WRITEERROR=1, go to DONE.
- BUSY:
  - Ignores DAT0_IN for the first 2 cycles (card turnaround).
  - Afterwards, the first DAT0_IN=1 sampled goes to DONE with no error.
  - If the busy counter reaches BUSY_TIMEOUT: NORESPERROR=1, go to DONE.
- DONE: COMPLT=1; error flags held; stays while ENA=1.
- ENA=0 in any state: next edge goes to IDLE; COMPLT and all error flags cleared; DATA_OE=0; RADDR=0. A mid-block abort drives no end bit.
- ENA held high through DONE never restarts a block. A new block needs ENA 0 then 1.
- At most one error flag is ever set per block.
- Counters are wide enough for BUSY_TIMEOUT (18 bits at default) and never wrap.

Test Plan:
1. RAM all 0, ENA=1, DAT0 idles high → exactly 1042 OE cycles:
   - DAT cycles: 0000, then 1024×0000, then 16×0000 (CRC 0x0000 on every line), then 1111.
   - No status token arrives: NORESPERROR=1 and COMPLT=1 exactly STATUS_TIMEOUT cycles after the end bit.
2. RAM[a]=a[3:0] → DATA_OUT on cycle k equals (k-1)[3:0] for k=1..1024.
   - Per-line CRCs match the bit-serial reference model.
   - RADDR sequence is 1,2,…,1023, then back to 0.
3. Card responds 3 cycles after the end bit with token 0,0,1,0,1, then holds DAT0 low 100 cycles, then high → COMPLT=1 the cycle after release, all error flags 0; ENA=0 → COMPLT=0 on the next edge.
4. Token 0,1,0,1,1 → CRCERROR=1, COMPLT=1, BUSY state skipped.
   - Token 0,1,1,0,1 → WRITEERROR=1.
   - Token 0,0,1,0,0 (bad end bit) → WRITEERROR=1.
5. ENA dropped at data nibble 500 → DATA_OE=0 and RADDR=0 on the next edge, no end bit driven, no flags set. Re-asserting ENA restarts from the start bit with CRC re-initialised.
6. RST pulsed low mid-BUSY → all outputs at reset values immediately (asynchronously). After RST returns high with ENA=1, a full new block is transmitted.
